// File: rtl/rr_capture_sched_pkg.sv
// Shared types and helpers for the round-robin capture scheduler.
// The rotate-priority pick is written once here so rr_pick stays a thin wrapper.
package rr_capture_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    // Widest requester vector the pick helper handles (NUM_REQ is 2..16).
    localparam int MAX_REQ = 16;
    localparam int PICK_W  = $clog2(MAX_REQ);

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req at or after ptr, wrapping modulo n; one-hot result.
    function automatic logic [MAX_REQ-1:0] rotate_pick(
        input logic [MAX_REQ-1:0] req,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int unsigned        idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[PICK_W-1:0]]) begin
                    pick[idx[PICK_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_capture_sched_rr_pick.sv
// Combinational rotate-priority encoder: one-hot grant plus binary winner index.
module rr_pick
    import rr_capture_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   winner
);

    logic [MAX_REQ-1:0] pick;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        pick   = rotate_pick(MAX_REQ'(req), 32'(ptr), NUM_REQ);
        gnt    = pick[NUM_REQ-1:0];
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) winner = PTR_W'(i);
        end
    end

endmodule

// File: rtl/rr_capture_sched.sv
// Round-robin scheduler sharing one registered capture stage between NUM_REQ requesters.
// Optional RR_CAPTURE_SCHED_LOCK_EN adds a `lock` input that pins priority on the last winner.
module rr_capture_sched
    import rr_capture_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
`ifdef RR_CAPTURE_SCHED_LOCK_EN
    input  logic                     lock,
`endif
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PTR_W-1:0]         gnt_idx
);

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   adv_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic               free;
    logic               grant_any;
    logic               hold_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .gnt    (pick_gnt),
        .winner (win)
    );

`ifdef RR_CAPTURE_SCHED_LOCK_EN
    // Holding the pointer on the winner keeps it first in line; a grant with
    // lock low, or the winner dropping req, lets rotation resume.
    assign hold_ptr = lock;
`else
    assign hold_ptr = 1'b0;
`endif

    always_comb begin
        free      = (state == IDLE) || (out_valid && out_ready);
        grant_any = rst_n && free && (|req);
        gnt       = grant_any ? pick_gnt : '0;
        adv_ptr   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
        next_ptr  = hold_ptr ? win : adv_ptr;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            gnt_idx   <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                        out_data  <= req_data[win*WIDTH +: WIDTH];
                        gnt_idx   <= win;
                        ptr       <= next_ptr;
                    end
                end
                FULL: begin
                    if (grant_any) begin
                        out_data  <= req_data[win*WIDTH +: WIDTH];
                        gnt_idx   <= win;
                        ptr       <= next_ptr;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_capture_sched.sv
// Directed self-checking bench for rr_capture_sched (NUM_REQ=4, WIDTH=8).
// Lock scenarios are compiled in only when RR_CAPTURE_SCHED_LOCK_EN is defined.
module tb_rr_capture_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        lock;
    logic [3:0]  gnt;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  gnt_idx;

    int checks = 0;
    int errors = 0;

    rr_capture_sched #(
        .NUM_REQ (4),
        .WIDTH   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
`ifdef RR_CAPTURE_SCHED_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gnt_idx   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; registered outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        lock = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        lock = 1'b0;
        req_data = 32'h44332211;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++; $display("FAIL reset_gnt cycle %0d: got %b expected 0000", c, gnt);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_valid cycle %0d: got %b expected 0", c, out_valid);
            end
            checks++;
            if (out_data !== 8'h00) begin
                errors++; $display("FAIL reset_data cycle %0d: got %h expected 00", c, out_data);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || gnt_idx !== 2'd0 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL reset_first_capture: got v=%b idx=%0d d=%h expected v=1 idx=0 d=11",
                     out_valid, gnt_idx, out_data);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt;
        logic [7:0] exp_data;
        do_reset();
        req_data = 32'h44332211;
        req = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt  = 4'b0001 << (k % 4);
            exp_data = 8'(8'h11 * ((k % 4) + 1));
            #1;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++; $display("FAIL rotation_gnt step %0d: got %b expected %b", k, gnt, exp_gnt);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data || gnt_idx !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rotation_out step %0d: got v=%b d=%h idx=%0d expected v=1 d=%h idx=%0d",
                         k, out_valid, out_data, gnt_idx, exp_data, k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_data = 32'h5AC33CA5;
        req = 4'b0001;
        out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++; $display("FAIL bp_first_capture: got v=%b d=%h expected v=1 d=a5", out_valid, out_data);
        end
        req = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000) begin
                errors++; $display("FAIL bp_stall_gnt cycle %0d: got %b expected 0000", c, gnt);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || gnt_idx !== 2'd0) begin
                errors++;
                $display("FAIL bp_stall_hold cycle %0d: got v=%b d=%h idx=%0d expected v=1 d=a5 idx=0",
                         c, out_valid, out_data, gnt_idx);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL bp_release_gnt: got %b expected 0010", gnt);
        end
        tick();
        checks++;
        if (out_data !== 8'h3C || gnt_idx !== 2'd1) begin
            errors++; $display("FAIL bp_release_data: got d=%h idx=%0d expected d=3c idx=1", out_data, gnt_idx);
        end
    endtask

    task automatic test_wrap_skip();
        logic [3:0] exp_gnt [3];
        logic [7:0] exp_data [3];
        exp_gnt  = '{4'b0001, 4'b0100, 4'b0001};
        exp_data = '{8'h11, 8'h33, 8'h11};
        do_reset();
        req_data = 32'h44332211;
        out_ready = 1'b1;
        req = 4'b0100;
        tick();
        req = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt !== exp_gnt[k]) begin
                errors++; $display("FAIL wrap_gnt step %0d: got %b expected %b", k, gnt, exp_gnt[k]);
            end
            tick();
            checks++;
            if (out_data !== exp_data[k]) begin
                errors++; $display("FAIL wrap_data step %0d: got %h expected %h", k, out_data, exp_data[k]);
            end
        end
    endtask

    task automatic test_drain();
        do_reset();
        req_data = 32'h44332211;
        out_ready = 1'b1;
        req = 4'b0010;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            errors++; $display("FAIL drain_capture: got v=%b d=%h expected v=1 d=22", out_valid, out_data);
        end
        req = 4'b0000;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL drain_gnt: got %b expected 0000", gnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_valid_fall: got %b expected 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_ready_ignored: got %b expected 0", out_valid);
        end
        // Capture from requester 2 so the pointer sits at 3 before reset hits.
        req = 4'b0100;
        tick();
        req = 4'b1111;
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL reset_full_gnt: got %b expected 0000", gnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_full_out: got v=%b d=%h idx=%0d expected v=0 d=00 idx=0",
                     out_valid, out_data, gnt_idx);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++; $display("FAIL reset_full_ptr: got %b expected 0001", gnt);
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req_data = 32'h44332211;
        out_ready = 1'b0;
        req = 4'b0001;
        tick();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++; $display("FAIL drop_gnt: got %b expected 0000", gnt);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drop_valid: got %b expected 0", out_valid);
        end
        req = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL drop_ptr_kept: got %b expected 0010", gnt);
        end
        tick();
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (gnt !== 4'b0100) begin
                errors++; $display("FAIL single_gnt cycle %0d: got %b expected 0100", c, gnt);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || gnt_idx !== 2'd2 || out_data !== 8'h33) begin
                errors++;
                $display("FAIL single_out cycle %0d: got v=%b idx=%0d d=%h expected v=1 idx=2 d=33",
                         c, out_valid, gnt_idx, out_data);
            end
        end
    endtask

`ifdef RR_CAPTURE_SCHED_LOCK_EN
    task automatic test_lock();
        do_reset();
        req_data = 32'h44332211;
        out_ready = 1'b1;
        req = 4'b0011;
        // Three locked grants, then the fourth grant to 0 arrives with lock low and releases.
        for (int k = 0; k < 4; k++) begin
            lock = (k < 3);
            #1;
            checks++;
            if (gnt !== 4'b0001) begin
                errors++; $display("FAIL lock_gnt step %0d: got %b expected 0001", k, gnt);
            end
            tick();
        end
        lock = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin
            errors++; $display("FAIL lock_release_gnt: got %b expected 0010", gnt);
        end
        tick();
        checks++;
        if (gnt_idx !== 2'd1 || out_data !== 8'h22) begin
            errors++; $display("FAIL lock_release_out: got idx=%0d d=%h expected idx=1 d=22", gnt_idx, out_data);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rotation();
        test_backpressure();
        test_wrap_skip();
        test_drain();
        test_req_drop();
`ifdef RR_CAPTURE_SCHED_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_capture_sched.md
Name: rr_capture_sched

Overview:
- Round-robin scheduler that shares one registered capture element (posedge-clocked data flop) between NUM_REQ requesters.
- Each cycle at most one requester is granted; its data is captured and presented downstream under a valid/ready handshake.
- Sits in front of the shared register primitive in the clock-detection test fabric. `clk` is the only clock; all other inputs are ordinary data inputs and must never be inferred as clocks.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 8, data width per requester
- PTR_W, $clog2(NUM_REQ), derived, width of round-robin pointer and `gnt_idx`

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- req  input  NUM_REQ  per-requester request, level, held until granted
- req_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- gnt  output  NUM_REQ  one-hot grant, combinational, valid in the capture cycle
- out_data  output  WIDTH  captured data, registered
- out_valid  output  1  `out_data` holds an unconsumed capture
- out_ready  input  1  downstream accepts `out_data` this cycle
- gnt_idx  output  PTR_W  index of the requester that produced `out_data`, registered

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; out_valid=0; out_data=0; gnt_idx=0; rr pointer=0 (requester 0 has highest priority). gnt=0 while rst_n=0.
- free = (state==IDLE) || (out_valid && out_ready).
- gnt is nonzero only when free && |req. It is one-hot and selects the first set req at or after the pointer, wrapping modulo NUM_REQ.
- On a posedge with a nonzero gnt:
  - out_data <= selected req_data
  - gnt_idx <= winner
  - out_valid <= 1
  - pointer <= (winner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0
- Latency: req seen in IDLE -> gnt same cycle -> out_valid=1 next cycle.
- FSM states:
  - IDLE: out_valid=0. Go to FULL on grant; otherwise stay.
  - FULL: out_valid=1, out_data stable while out_ready=0.
    - out_ready=1 with a grant: stay FULL and load new data (back-to-back, no bubble).
    - out_ready=1 with no req: go to IDLE; out_valid=0 next cycle.
- Simultaneous events:
  - All req set: grants rotate strictly 0,1,2,3,0,...
  - A single persistent requester is granted every free cycle.
- Stall: out_ready=0 in FULL -> gnt=0; pointer, out_data and gnt_idx hold.
- Reset mid-transfer: pending capture is discarded; out_valid=0 the cycle after reset is sampled; pointer returns to 0.
- req dropped before grant: no capture and no pointer change.
- out_ready while IDLE is ignored.

Optional Feature:
- Macro: RR_CAPTURE_SCHED_LOCK_EN.
- Defined:
  - Adds port `lock` (input, 1).
  - If lock=1 during a grant, the pointer is not advanced past the winner. That winner keeps top priority on subsequent free cycles while its req and lock stay high.
  - Lock releases when lock=0 at a grant, or when the winner's req=0; the pointer then advances normally.
- Undefined: no `lock` port; pure round-robin as above.

Decomposition:
- Package rr_capture_sched_pkg:
  - state enum {IDLE, FULL}
  - localparam helper for PTR_W
  - function rotate_pick(req, ptr) returning one-hot
- Sub-module rr_pick: combinational rotate-priority encoder. Inputs req and ptr; outputs one-hot gnt and binary winner index. Instantiated once.

Test Plan:
- Reset: hold rst_n=0 3 cycles with req=4'b1111 -> gnt=0, out_valid=0, out_data=0 throughout; first grant after release goes to 0.
- Full rotation: req=4'b1111, out_ready=1, req_data={8'h44,8'h33,8'h22,8'h11} -> out_data sequence 11,22,33,44,11 on consecutive cycles; gnt_idx 0,1,2,3,0; out_valid never drops.
- Backpressure: one capture of 8'hA5, then out_ready=0 for 5 cycles with req=4'b0110 -> gnt=0, out_data=A5 stable; on out_ready=1, gnt=4'b0010 that cycle.
- Wrap and skip: pointer=3, req=4'b0101 -> gnt=4'b0001, then 4'b0100, then 4'b0001.
- Drain to IDLE: single capture, req=0, out_ready=1 -> out_valid falls the next cycle and the FSM returns to IDLE; reset asserted while FULL -> out_valid=0 the next cycle.
- Lock (RR_CAPTURE_SCHED_LOCK_EN defined): req=4'b0011, lock=1 -> requester 0 is granted 4 consecutive times; lock=0 -> next grant goes to requester 1.
